// File: rtl/avalon_ram_agent_pkg.sv
// rtl/avalon_ram_agent_pkg.sv - shared types and helpers for the Avalon-MM RAM agent
package avalon_ram_agent_pkg;

  localparam int unsigned WORD_BYTES = 4;

  typedef enum logic [1:0] {
    WS_IDLE,
    WS_WAIT,
    WS_ACCEPT
  } wait_state_t;

  // Byte at offset k is big-endian within the word: its lane's msb is 31-8k.
  function automatic int unsigned lane_of(input int unsigned offset);
    return 31 - 8 * offset;
  endfunction

endpackage

// File: rtl/avalon_ram_agent_if.sv
// rtl/avalon_ram_agent_if.sv - Avalon-MM read/write bus between a host and the RAM agent
interface avalon_ram_agent_if;
  logic [31:0] address;
  logic        read;
  logic        write;
  logic [3:0]  byteenable;
  logic [31:0] host_to_agent;
  logic [31:0] agent_to_host;
  logic        readdatavalid;
  logic        waitrequest;

  modport master (
    output address, read, write, byteenable, host_to_agent,
    input  agent_to_host, readdatavalid, waitrequest
  );

  modport slave (
    input  address, read, write, byteenable, host_to_agent,
    output agent_to_host, readdatavalid, waitrequest
  );
endinterface

// File: rtl/avalon_ram_agent_read_latency_pipe.sv
// rtl/avalon_ram_agent_read_latency_pipe.sv - valid/data shift register giving fixed read latency
module avalon_ram_agent_read_latency_pipe #(
  parameter int unsigned LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_i,
  input  logic [31:0] data_i,
  output logic        valid_o,
  output logic [31:0] data_o
);

  logic [LATENCY-1:0] valid_q;
  logic [31:0]        data_q [LATENCY];

  // Data stages only move with a valid token, so the last stage holds the last returned word.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
      for (int unsigned i = 0; i < LATENCY; i++) data_q[i] <= '0;
    end else begin
      valid_q[0] <= valid_i;
      if (valid_i) data_q[0] <= data_i;
      for (int unsigned i = 1; i < LATENCY; i++) begin
        valid_q[i] <= valid_q[i-1];
        if (valid_q[i-1]) data_q[i] <= data_q[i-1];
      end
    end
  end

  assign valid_o = valid_q[LATENCY-1];
  assign data_o  = data_q[LATENCY-1];

endmodule

// File: rtl/avalon_ram_agent.sv
// rtl/avalon_ram_agent.sv - word RAM behind an Avalon-MM agent with pipelined reads
// AVALON_RAM_WAIT_EN adds a wait-state FSM inserting WAIT_CYCLES waitrequest cycles per command.
module avalon_ram_agent
  import avalon_ram_agent_pkg::*;
#(
  parameter int unsigned DEPTH        = 1024,
  parameter int unsigned READ_LATENCY = 1
`ifdef AVALON_RAM_WAIT_EN
  , parameter int unsigned WAIT_CYCLES = 2
`endif
) (
  input  logic            clk,
  input  logic            rst,
  avalon_ram_agent_if.slave bus
);

  localparam int unsigned IDX_W = $clog2(DEPTH);

  logic [31:0]      mem_q [DEPTH];
  logic [IDX_W-1:0] idx;
  logic             cmd;
  logic             waitreq;
  logic             accept;
  logic             wr_accept;
  logic             rd_accept;
  logic             unused_addr;

  assign idx         = bus.address[IDX_W+1:2];
  assign unused_addr = ^{bus.address[31:IDX_W+2], bus.address[1:0]};
  assign cmd         = bus.read | bus.write;
  assign accept      = rst & cmd & ~waitreq;
  assign wr_accept   = accept & bus.write;
  assign rd_accept   = accept & bus.read & ~bus.write;

`ifdef AVALON_RAM_WAIT_EN
  wait_state_t state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= WS_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // cnt_q counts waitrequest cycles already spent, the IDLE-with-command cycle included.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    waitreq = 1'b0;
    unique case (state_q)
      WS_IDLE: begin
        if (cmd) begin
          waitreq = 1'b1;
          cnt_d   = 4'd1;
          state_d = (WAIT_CYCLES == 1) ? WS_ACCEPT : WS_WAIT;
        end
      end
      WS_WAIT: begin
        waitreq = 1'b1;
        if (!cmd) begin
          state_d = WS_IDLE;
        end else if (cnt_q + 4'd1 == 4'(WAIT_CYCLES)) begin
          state_d = WS_ACCEPT;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      WS_ACCEPT: state_d = WS_IDLE;
      default:   state_d = WS_IDLE;
    endcase
    if (!rst) waitreq = 1'b0;
  end
`else
  assign waitreq = 1'b0;
`endif

  // Storage is deliberately not reset; the write is gated by rst so a reset edge drops it.
  always_ff @(posedge clk) begin
    if (wr_accept) begin
      for (int unsigned k = 0; k < WORD_BYTES; k++) begin
        if (bus.byteenable[2'(3 - k)])
          mem_q[idx][5'(lane_of(k)) -: 8] <= bus.host_to_agent[5'(lane_of(k)) -: 8];
      end
    end
  end

  avalon_ram_agent_read_latency_pipe #(
    .LATENCY (READ_LATENCY)
  ) u_read_pipe (
    .clk     (clk),
    .rst     (rst),
    .valid_i (rd_accept),
    .data_i  (mem_q[idx]),
    .valid_o (bus.readdatavalid),
    .data_o  (bus.agent_to_host)
  );

  assign bus.waitrequest = waitreq;

endmodule
